// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like data-bus master.
// Holds the transaction FSM state type, the access-size encoding and the
// size-dependent helpers used by both the master and the load aligner.
package sram_like_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // The reserved encoding 2'b11 behaves as a word access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

  // Replicate right-justified store data onto every lane the size covers.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (norm_size(size))
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (norm_size(size))
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data aligner: picks the addressed byte/half lane out of a bus word and
// sign- or zero-extends it. Purely combinational so the instruction side can
// reuse it.
module mem_load_align
  import sram_like_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by extension; word (and reserved 2'b11) pass through.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/sram_like_master.sv
// SRAM-like data-bus initiator for the MEM stage.
// Converts one held load/store into a single bus transaction, stalls the
// pipeline until it completes and returns aligned/extended load data.
// Optional build macro ADDR_ERR_EN: misaligned half/word requests skip the
// bus and complete immediately with a mem_addr_err pulse.
//
// state | meaning
// IDLE  | no transaction; sample mem_req and capture the request
// REQ   | data_req high, waiting for data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | one-cycle completion: mem_done, mem_rdata valid
module sram_like_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  mem_addr_err,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [31:0]           data_wdata,
  input  logic [31:0]           data_rdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok
);
  import sram_like_pkg::*;

  state_t                state;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  misalign;
  logic [31:0]           aligned;

`ifdef ADDR_ERR_EN
  assign misalign     = misaligned(mem_size, mem_addr[1:0]);
  assign mem_addr_err = (state == DONE) && err_q;
`else
  assign misalign     = 1'b0;
  assign mem_addr_err = 1'b0;
`endif

  // Transaction FSM plus request/response capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            wr_q    <= mem_wr;
            size_q  <= norm_size(mem_size);
            sign_q  <= mem_signed;
            addr_q  <= mem_addr;
            wdata_q <= lane_wdata(mem_size, mem_wdata);
            err_q   <= misalign;
            state   <= misalign ? DONE : REQ;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              rdata_q <= data_rdata;
              state   <= DONE;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            rdata_q <= data_rdata;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_load_align u_align (
    .rdata    (rdata_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .result   (aligned)
  );

  // Bus fields come only from captured registers so they stay stable in REQ.
  assign data_req   = (state == REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

  assign mem_done  = (state == DONE);
  assign mem_stall = mem_req && (state != DONE);
  assign mem_rdata = (mem_done && !wr_q && !err_q) ? aligned : 32'h0;

endmodule

// File: tb/tb_sram_like_master.sv
module tb_sram_like_master;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req, mem_wr, mem_signed;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_stall, mem_done, mem_addr_err;
  logic [31:0]   mem_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          data_addr_ok, data_data_ok;

  int total = 0;
  int bad = 0;
  int a_delay = 0;
  int r_delay = 0;
  logic [7:0]  ref_mem  [0:255];
  logic [31:0] resp_mem [0:63];

  always #5 clk = ~clk;

  sram_like_master #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_addr_err(mem_addr_err),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  function automatic logic [31:0] seed_word(input int i);
    logic [31:0] t;
    t = i + 1;
    return 32'h9E3779B9 * t;
  endfunction

  function automatic bit lane_en(input logic [1:0] sz, input logic [1:0] a, input int b);
    if (sz == 2'b00) return b == int'(a);
    if (sz == 2'b01) return (b / 2) == int'(a[1]);
    return 1'b1;
  endfunction

  // Reference memory as plain little-endian bytes.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int base;
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = {24'h0, ref_mem[a[7:0]]};
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      base = int'(a[7:0]) & 'hFE;
      v = {16'h0, ref_mem[base+1], ref_mem[base]};
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      base = int'(a[7:0]) & 'hFC;
      v = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int base;
    if (sz == 2'b00) begin
      ref_mem[a[7:0]] = wd[7:0];
    end else if (sz == 2'b01) begin
      base = int'(a[7:0]) & 'hFE;
      ref_mem[base] = wd[7:0]; ref_mem[base+1] = wd[15:8];
    end else begin
      base = int'(a[7:0]) & 'hFC;
      for (int j = 0; j < 4; j++) ref_mem[base+j] = wd[8*j +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responder: addr_ok after a_delay cycles of data_req, data_ok r_delay cycles later.
  initial begin : responder
    int acnt, rcnt, wi;
    bit pend;
    logic [31:0] rd_val;
    acnt = 0; rcnt = 0; pend = 0; rd_val = 0; wi = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    for (int i = 0; i < 64; i++) resp_mem[i] = seed_word(i);
    forever begin
      @(negedge clk);
      data_addr_ok = 0; data_data_ok = 0;
      if (pend) begin
        if (rcnt <= 1) begin data_data_ok = 1; data_rdata = rd_val; pend = 0; end
        else rcnt--;
      end else if (!rst_n) begin
        acnt = 0;
      end else if (data_req) begin
        if (acnt < a_delay) acnt++;
        else begin
          data_addr_ok = 1; acnt = 0;
          wi = int'(data_addr[7:2]);
          if (data_wr) begin
            for (int b = 0; b < 4; b++)
              if (lane_en(data_size, data_addr[1:0], b)) resp_mem[wi][8*b +: 8] = data_wdata[8*b +: 8];
            rd_val = $urandom;
          end else begin
            rd_val = resp_mem[wi];
          end
          if (r_delay == 0) begin data_data_ok = 1; data_rdata = rd_val; end
          else begin pend = 1; rcnt = r_delay; end
        end
      end
    end
  end

  // One transaction, issued at a negedge; cycle k = k-th following negedge.
  task automatic run_op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int ad, input int rd,
                        input bit drop, input bit err);
    logic [1:0] esz;
    logic [31:0] ewd, erd;
    int req_cyc, done_at;
    esz = (sz == 2'b11) ? 2'b10 : sz;
    ewd = (esz == 2'b00) ? wd[7:0] * 32'h01010101 : (esz == 2'b01) ? wd[15:0] * 32'h00010001 : wd;
    erd = (wr || err) ? 32'h0 : ref_load(esz, sg, addr);
    a_delay = ad; r_delay = rd;
    mem_req = 1; mem_wr = wr; mem_size = sz; mem_signed = sg; mem_addr = addr; mem_wdata = wd;
    req_cyc = 0; done_at = 0;
    for (int k = 1; k <= 64 && done_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " stall"}, {31'h0, mem_stall}, {31'h0, !err});
      if (data_req) begin
        req_cyc++;
        chk({tag, " wr/size"}, {29'h0, data_wr, data_size}, {29'h0, wr, esz});
        chk({tag, " addr"}, data_addr, addr);
        if (wr) chk({tag, " wdata"}, data_wdata, ewd);
      end
      if (mem_done) begin
        done_at = k;
        chk({tag, " rdata"}, mem_rdata, erd);
        chk({tag, " addr_err"}, {31'h0, mem_addr_err}, {31'h0, err});
        chk({tag, " stall@done"}, {31'h0, mem_stall}, 32'h0);
      end
      if (drop && k == 1) mem_req = 0;
    end
    chk({tag, " done_cycle"}, done_at, err ? 1 : 2 + ad + rd);
    chk({tag, " req_cycles"}, req_cyc, err ? 0 : ad + 1);
    mem_req = 0;
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'h0, mem_done}, 32'h0);
    if (wr && !err) ref_store(esz, addr, wd);
  endtask

  initial begin
    logic [31:0] w;
    mem_req = 0; mem_wr = 0; mem_size = 0; mem_signed = 0; mem_addr = 0; mem_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      w = seed_word(i);
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[8*j +: 8];
    end
    repeat (3) @(negedge clk);
    chk("rst data_req", {31'h0, data_req}, 0);
    chk("rst mem_done", {31'h0, mem_done}, 0);
    chk("rst mem_stall", {31'h0, mem_stall}, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst addr_err", {31'h0, mem_addr_err}, 0);
    chk("rst bus", {29'h0, data_wr, data_size}, 0);
    chk("rst data_addr", data_addr, 0);
    chk("rst data_wdata", data_wdata, 0);
    rst_n = 1;
    @(negedge clk);

    run_op("st_word",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0);
    run_op("ld_word",  0, 2'b10, 0, 32'h10, 32'h0, 0, 3, 0, 0);
    run_op("st_word2", 1, 2'b10, 0, 32'h10, 32'h80FF1234, 0, 0, 0, 0);
    run_op("ld_sbyte", 0, 2'b00, 1, 32'h13, 32'h0, 0, 1, 0, 0);
    run_op("ld_ubyte", 0, 2'b00, 0, 32'h13, 32'h0, 1, 0, 0, 0);
    run_op("ld_shalf", 0, 2'b01, 1, 32'h12, 32'h0, 0, 2, 0, 0);
    run_op("st_byte",  1, 2'b00, 0, 32'h21, 32'h000000AB, 0, 1, 0, 0);
    run_op("ld_w20",   0, 2'b10, 0, 32'h20, 32'h0, 0, 0, 0, 0);
    run_op("slow_ack", 0, 2'b10, 0, 32'h30, 32'h0, 4, 0, 0, 0);
    run_op("drop_req", 0, 2'b01, 0, 32'h40, 32'h0, 1, 2, 1, 0);
    run_op("size11",   0, 2'b11, 1, 32'h44, 32'h0, 0, 1, 0, 0);

    // Reset while waiting for the response; stale data_ok lands after release.
    a_delay = 0; r_delay = 5;
    mem_req = 1; mem_wr = 0; mem_size = 2'b10; mem_signed = 0; mem_addr = 32'h10;
    @(negedge clk);
    chk("rstw req_c1", {31'h0, data_req}, 1);
    repeat (2) @(negedge clk);
    rst_n = 0; mem_req = 0;
    #1;
    chk("rstw data_req", {31'h0, data_req}, 0);
    chk("rstw mem_done", {31'h0, mem_done}, 0);
    @(negedge clk);
    chk("rstw in_rst", {31'h0, mem_done}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw post done", {31'h0, mem_done}, 0);
      chk("rstw post req", {31'h0, data_req}, 0);
    end
    run_op("after_rstw", 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 0, 0);

    // Reset while requesting: data_req must drop without waiting for a clock.
    a_delay = 3; r_delay = 0;
    mem_req = 1; mem_wr = 0; mem_size = 2'b10; mem_addr = 32'h20;
    @(negedge clk);
    chk("rstr req_c1", {31'h0, data_req}, 1);
    @(negedge clk);
    rst_n = 0; mem_req = 0;
    #1;
    chk("rstr async drop", {31'h0, data_req}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_op("after_rstr", 0, 2'b00, 1, 32'h22, 32'h0, 2, 1, 0, 0);

`ifdef ADDR_ERR_EN
    run_op("misalign", 0, 2'b10, 0, 32'h22, 32'h0, 0, 0, 0, 1);
`else
    run_op("misalign", 0, 2'b10, 0, 32'h22, 32'h0, 0, 0, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63)) * 4;
      if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
      else if (sz == 2'b01) a = a + 32'($urandom_range(0, 1)) * 2;
      run_op("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_like_master.md
Name: sram_like_master

Overview:
- Initiator side of the SRAM-like data bus: `data_req`/`data_wr`/`data_size`/`data_addr`/`data_wdata` out; `data_addr_ok`/`data_data_ok`/`data_rdata` in.
- Sits between the CPU MEM stage and the data-memory responder. Turns a held MEM-stage load/store into one bus transaction.
- Stalls the pipeline until the transaction completes.
- Replicates store lanes, and aligns and extends load data.
- One transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and data_addr.

Ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  reset, asynchronous, active-low
mem_req  in  1  MEM stage has a load/store; held until mem_done
mem_wr  in  1  1 = store, 0 = load
mem_size  in  2  00 byte, 01 half, 10 word
mem_signed  in  1  loads: sign-extend (1) or zero-extend (0)
mem_addr  in  ADDR_WIDTH  byte address
mem_wdata  in  32  store data, right-justified
mem_stall  out  1  hold pipeline
mem_done  out  1  one-cycle completion pulse
mem_rdata  out  32  aligned and extended load result, valid with mem_done
mem_addr_err  out  1  misaligned-access pulse (ADDR_ERR_EN only)
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size, same encoding as mem_size
data_addr  out  ADDR_WIDTH  bus address (unmodified byte address)
data_wdata  out  32  lane-replicated store data
data_rdata  in  32  bus read data
data_addr_ok  in  1  request accepted (may be combinational on data_req)
data_data_ok  in  1  response valid

Behaviour:
- Reset values: all outputs 0; state IDLE; captured request and rdata registers 0.
- Reset mid-transaction aborts immediately: data_req drops asynchronously.
- States:
  - IDLE: on mem_req, register mem_wr/size/signed/addr/wdata and go to REQ.
  - REQ: data_req=1, bus fields driven from registers only.
    - addr_ok && data_ok in the same cycle: capture rdata, go to DONE.
    - addr_ok only: go to WAIT.
    - Otherwise stay in REQ with data_req and all fields held stable.
  - WAIT: data_req=0. On data_ok, capture data_rdata and go to DONE.
  - DONE: mem_done=1 for exactly one cycle, mem_rdata valid, then IDLE.
- mem_stall = mem_req && state!=DONE.
  - IDLE re-issues on a held mem_req only after DONE returns to IDLE, so the next instruction's request is sampled with no gap.
- Latency: mem_req seen at cycle 0 → data_req at cycle 1 → with responder delay D, data_ok at 1+D → mem_done at 2+D.
- Store lanes on data_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Load extraction:
  - byte: lane addr[1:0] of rdata.
  - half: lane addr[1] of rdata.
  - Extension per captured mem_signed.
  - Word: rdata unchanged.
  - For stores, mem_rdata = 0.
- A data_data_ok arriving in IDLE, REQ without addr_ok, or DONE is ignored.
- mem_req falling while in REQ/WAIT does not cancel: the transaction completes and mem_done still pulses.
- mem_size=11 is treated as word.

Optional Feature:
- ADDR_ERR_EN defined:
  - In IDLE, a misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) issues no bus request.
  - Goes to DONE; mem_addr_err and mem_done pulse together; mem_rdata=0.
- Undefined: mem_addr_err is tied to 0 and misaligned requests go to the bus unchanged.

Decomposition:
- Package sram_like_pkg holds:
  - state enum {IDLE, REQ, WAIT, DONE}
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
- Sub-module mem_load_align: purely combinational (rdata, addr[1:0], size, signed) → aligned result. Reusable by the instruction side.

Test Plan:
- Word load, addr 0x10, responder holds 0xDEADBEEF at word 4, delay 3 → data_req high cycle 1 only; mem_done at cycle 5; mem_rdata=0xDEADBEEF.
- Signed byte load, addr 0x13, word 0x80FF1234 → mem_rdata=0xFFFFFF80. Unsigned → 0x00000080. Signed half at 0x12 → 0xFFFF80FF.
- Byte store, wdata 0x000000AB, addr 0x21 → data_wdata=0xABABABAB, data_size=00; a later word load of 0x20 shows 0xAB in bits 15:8 only.
- Responder with addr_ok held low 4 cycles then high, data_ok same cycle → data_req/fields stable for 5 cycles; mem_done one cycle later; no WAIT visit.
- rst_n low during WAIT, with data_ok arriving 1 cycle after reset release → data_req=0 and mem_done stays 0; next request completes normally.
- ADDR_ERR_EN: word load at 0x22 → no data_req; mem_addr_err and mem_done pulse at cycle 1.
